vedic_8b: RTL and testbench



---
 rtl/vedic_8b.sv | 128 ++++++++++++
 tb/tb_vedic_8b.sv | 115 +++++++++++
 2 files changed

// File: rtl/vedic_8b.sv
// Unsigned 8x8 -> 16 Urdhva-Tiryagbhyam multiplier with a registered product and valid flag.
// Optional VEDIC_8B_PIPE_EN inserts a register stage on the four 4x4 partial products (latency 2).

module vedic_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = x ^ y;
    assign co = x & y;
endmodule

module vedic_2x2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);
    logic k;

    assign p[0] = x[0] & y[0];

    vedic_ha ha_mid (
        .x  (x[1] & y[0]),
        .y  (x[0] & y[1]),
        .s  (p[1]),
        .co (k)
    );

    vedic_ha ha_top (
        .x  (x[1] & y[1]),
        .y  (k),
        .s  (p[2]),
        .co (p[3])
    );
endmodule

module vedic_4x4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] r
);
    logic [3:0] q0, q1, q2, q3;
    logic [5:0] s;

    vedic_2x2 m_ll (.x(x[1:0]), .y(y[1:0]), .p(q0));
    vedic_2x2 m_hl (.x(x[3:2]), .y(y[1:0]), .p(q1));
    vedic_2x2 m_lh (.x(x[1:0]), .y(y[3:2]), .p(q2));
    vedic_2x2 m_hh (.x(x[3:2]), .y(y[3:2]), .p(q3));

    // Crosswise sum: max 9 + 9 + 3 = 21, fits in 6 bits.
    assign s      = {2'b00, q1} + {2'b00, q2} + {4'b0000, q0[3:2]};
    assign r[1:0] = q0[1:0];
    assign r[3:2] = s[1:0];
    assign r[7:4] = q3 + s[5:2];
endmodule

module vedic_8b (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        in_valid,
    output logic [15:0] c,
    output logic        out_valid
);
    logic [7:0]  q0, q1, q2, q3;
    logic [7:0]  q0_m, q1_m, q2_m, q3_m;
    logic        vld_m;
    logic [9:0]  s;
    logic [15:0] prod;

    vedic_4x4 m_ll (.x(a[3:0]), .y(b[3:0]), .r(q0));
    vedic_4x4 m_hl (.x(a[7:4]), .y(b[3:0]), .r(q1));
    vedic_4x4 m_lh (.x(a[3:0]), .y(b[7:4]), .r(q2));
    vedic_4x4 m_hh (.x(a[7:4]), .y(b[7:4]), .r(q3));

`ifdef VEDIC_8B_PIPE_EN
    logic [7:0] q0_p0, q1_p0, q2_p0, q3_p0;
    logic       vld_p0;

    // Stage p0: partial products registered
    always_ff @(posedge clk) begin
        if (rst) begin
            q0_p0  <= '0;
            q1_p0  <= '0;
            q2_p0  <= '0;
            q3_p0  <= '0;
            vld_p0 <= 1'b0;
        end else begin
            q0_p0  <= q0;
            q1_p0  <= q1;
            q2_p0  <= q2;
            q3_p0  <= q3;
            vld_p0 <= in_valid;
        end
    end

    assign q0_m  = q0_p0;
    assign q1_m  = q1_p0;
    assign q2_m  = q2_p0;
    assign q3_m  = q3_p0;
    assign vld_m = vld_p0;
`else
    assign q0_m  = q0;
    assign q1_m  = q1;
    assign q2_m  = q2;
    assign q3_m  = q3;
    assign vld_m = in_valid;
`endif

    // Max 225 + 225 + 15 = 465 fits in 10 bits; top byte cannot carry out since a*b <= 0xFE01.
    assign s          = {2'b00, q1_m} + {2'b00, q2_m} + {6'b000000, q0_m[7:4]};
    assign prod[3:0]  = q0_m[3:0];
    assign prod[7:4]  = s[3:0];
    assign prod[15:8] = q3_m + {2'b00, s[9:4]};

    // Output stage: product and valid registered
    always_ff @(posedge clk) begin
        if (rst) begin
            c         <= '0;
            out_valid <= 1'b0;
        end else begin
            c         <= prod;
            out_valid <= vld_m;
        end
    end
endmodule

// File: tb/tb_vedic_8b.sv
// Self-checking bench for vedic_8b: directed cases, random traffic with resets, exhaustive sweep.
// Reference model is plain a*b through a latency-deep delay line.

module tb_vedic_8b;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  a = 8'hFF;
    logic [7:0]  b = 8'hFF;
    logic        in_valid = 1'b1;
    logic [15:0] c;
    logic        out_valid;

`ifdef VEDIC_8B_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model delay line: {valid, product}; index LAT-1 is what c/out_valid should show.
    logic [16:0] mdl [LAT];

    vedic_8b dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .c         (c),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic [7:0] ta, input logic [7:0] tb_in, input logic tv, input logic tr);
        logic [15:0] full;
        a        = ta;
        b        = tb_in;
        in_valid = tv;
        rst      = tr;
        full     = 16'(ta) * 16'(tb_in);
        @(posedge clk);
        if (tr) begin
            for (int i = 0; i < LAT; i++) mdl[i] = '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) mdl[i] = mdl[i-1];
            mdl[0] = {tv, full};
        end
        @(negedge clk);
        check("c", c, mdl[LAT-1][15:0]);
        check("out_valid", {15'b0, out_valid}, {15'b0, mdl[LAT-1][16]});
    endtask

    task automatic flush();
        for (int i = 0; i < LAT; i++) cycle(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) mdl[i] = '0;

        // Reset held two cycles with max operands and valid asserted
        cycle(8'hFF, 8'hFF, 1'b1, 1'b1);
        check("rst_c", c, 16'h0000);
        cycle(8'hFF, 8'hFF, 1'b1, 1'b1);
        check("rst_c2", c, 16'h0000);
        check("rst_vld", {15'b0, out_valid}, 16'h0000);

        // Maximum product
        cycle(8'd255, 8'd255, 1'b1, 1'b0);
        flush();

        // Back-to-back
        cycle(8'd153, 8'd47, 1'b1, 1'b0);
        cycle(8'd31, 8'd63, 1'b1, 1'b0);
        flush();

        // Zero and power-of-two operands, then valid dropped
        cycle(8'h00, 8'hA5, 1'b1, 1'b0);
        cycle(8'h01, 8'h80, 1'b1, 1'b0);
        cycle(8'h37, 8'h59, 1'b0, 1'b0);
        flush();

        // Reset while a product is in flight
        cycle(8'd200, 8'd199, 1'b1, 1'b0);
        cycle(8'd77, 8'd88, 1'b1, 1'b1);
        cycle(8'd12, 8'd12, 1'b1, 1'b0);
        flush();

        // Random traffic with sparse valid and occasional reset
        for (int i = 0; i < 3000; i++) begin
            cycle(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 63) == 0));
        end
        flush();

        // Exhaustive sweep
        for (int i = 0; i < 65536; i++) begin
            cycle(8'(i >> 8), 8'(i), 1'b1, 1'b0);
        end
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
